async_fifo_rd_adapter: RTL and testbench

- Read-side consumer for the async FIFO, placed in the read clock domain.
- Turns the FIFO pop interface (empty flag, read enable, 1-cycle-latency read data) into a valid/ready stream for downstream logic.
- A small elastic buffer gives full throughput under backpressure and never over-pops.
- Also keeps a running count of words delivered.

---
 rtl/async_fifo_pkg.sv | 10 +
 rtl/async_fifo_rd_adapter_if.sv | 17 +
 rtl/rd_elastic_buf.sv | 75 +++++++
 rtl/async_fifo_rd_adapter.sv | 83 ++++++++
 tb/tb_async_fifo_rd_adapter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read side.
//   FIFO_WIDTH      : default data word width of the async FIFO.
//   FIFO_RD_LATENCY : cycles from the pop request to its data being captured.
//   word_t          : one FIFO data word at the default width.
package async_fifo_pkg;
  localparam int FIFO_WIDTH      = 4;
  localparam int FIFO_RD_LATENCY = 1;

  typedef logic [FIFO_WIDTH-1:0] word_t;
endpackage

// File: rtl/async_fifo_rd_adapter_if.sv
// Valid/ready stream bundle.
//   valid : producer has a word on data.
//   ready : consumer accepts; a transfer happens on a clock edge where
//           valid & ready are both high. Once valid is raised, it and data
//           stay put until that transfer happens.
//   data  : W-bit payload.
// Modports: master = producer side, slave = consumer side.
interface async_fifo_rd_adapter_if #(
  parameter int W = 4
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rd_elastic_buf.sv
// Circular elastic buffer sitting behind the FIFO pop port.
//   i_clk, i_rst_n : clock, asynchronous active-low reset.
//   i_push         : write i_push_data at the tail this cycle.
//   i_push_data    : word to write.
//   m_out          : stream master; valid = not empty, data = head word.
//   o_occ          : current occupancy, 0..DEPTH.
module rd_elastic_buf
  import async_fifo_pkg::*;
#(
  parameter int W     = FIFO_WIDTH,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_data,
  async_fifo_rd_adapter_if.master m_out,
  output logic [OCC_W-1:0]       o_occ
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             pop;

  assign pop = (occ_q != '0) && m_out.ready;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      // Explicit compare so a non-power-of-2 depth wraps correctly.
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({i_push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign m_out.valid = (occ_q != '0);
  assign m_out.data  = mem_q[rd_ptr_q];
  assign o_occ       = occ_q;

  // The issue logic upstream reserves space before popping, so a push into
  // a full buffer without a simultaneous pop never happens.
  a_occ_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    occ_q <= OCC_W'(DEPTH));
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !pop && (occ_q == OCC_W'(DEPTH))));
endmodule

// File: rtl/async_fifo_rd_adapter.sv
// Read-side consumer for the async FIFO: turns the pop interface into a
// valid/ready stream and counts delivered words.
//   i_clk, i_rst_n : read-domain clock, asynchronous active-low reset.
//   i_en           : allows new pops.
//   i_fifo_empty   : pessimistic empty flag from the FIFO.
//   o_fifo_ren     : registered pop request.
//   i_fifo_rdata   : FIFO data, captured in the cycle o_fifo_ren is high.
//   o_valid, i_ready, o_data : output stream.
//   o_count        : accepted transfers modulo 2^CNT_WIDTH.
module async_fifo_rd_adapter
  import async_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = async_fifo_pkg::FIFO_WIDTH,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_ren,
  input  logic [FIFO_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [FIFO_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_count
);
  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;

  async_fifo_rd_adapter_if #(.W(FIFO_WIDTH)) stream_if ();

  logic                 ren_q, ren_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [OCC_W-1:0]     occ;
  logic [OCC_W-1:0]     committed;
  logic                 infl;
  logic                 pop;

  // The word requested by the current o_fifo_ren lands in the buffer at the
  // next edge, so the request itself is the in-flight flag.
  assign infl = ren_q;
  assign pop  = o_valid & i_ready;

  rd_elastic_buf #(
    .W     (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (infl),
    .i_push_data (i_fifo_rdata),
    .m_out       (stream_if),
    .o_occ       (occ)
  );

  assign stream_if.ready = i_ready;
  assign o_valid         = stream_if.valid;
  assign o_data          = stream_if.data;

  always_comb begin
    // Words the buffer will hold after this edge; pop implies occ >= 1, so
    // the subtraction never wraps.
    committed = occ + OCC_W'(infl) - OCC_W'(pop);
    ren_d     = i_en & ~i_fifo_empty & (committed < OCC_W'(BUF_DEPTH));
    count_d   = count_q + CNT_WIDTH'(pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ren_q   <= 1'b0;
      count_q <= '0;
    end else begin
      ren_q   <= ren_d;
      count_q <= count_d;
    end
  end

  assign o_fifo_ren = ren_q;
  assign o_count    = count_q;

  a_no_pop_when_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(ren_d && i_fifo_empty));
endmodule

// File: tb/tb_async_fifo_rd_adapter.sv
module tb_async_fifo_rd_adapter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       force_empty;
  logic       fifo_empty;
  logic       o_fifo_ren, ren2;
  logic [3:0] fifo_rdata;
  logic       valid2;
  logic [3:0] data2;
  logic [7:0] count8;
  logic [3:0] count4;

  int errors = 0;
  int checks = 0;

  // FIFO model: write pointer driven by the stimulus, read pointer advanced
  // by the DUT pop request. Empty accounts for the pop already in progress.
  logic [3:0] fmem [64];
  int         wptr = 0;
  int         rptr;
  int         ren_pulses = 0;
  logic [3:0] got_q [$];
  logic [3:0] exp_q [$];

  async_fifo_rd_adapter_if #(.W(4)) sif ();

  assign fifo_empty = force_empty || ((wptr - rptr) <= (o_fifo_ren ? 1 : 0));
  assign fifo_rdata = fmem[rptr % 64];

  async_fifo_rd_adapter #(.FIFO_WIDTH(4), .BUF_DEPTH(2), .CNT_WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_fifo_empty(fifo_empty),
    .o_fifo_ren(o_fifo_ren), .i_fifo_rdata(fifo_rdata),
    .o_valid(sif.valid), .i_ready(sif.ready), .o_data(sif.data),
    .o_count(count8)
  );

  async_fifo_rd_adapter #(.FIFO_WIDTH(4), .BUF_DEPTH(2), .CNT_WIDTH(4)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_fifo_empty(fifo_empty),
    .o_fifo_ren(ren2), .i_fifo_rdata(fifo_rdata),
    .o_valid(valid2), .i_ready(sif.ready), .o_data(data2),
    .o_count(count4)
  );

  // clock / reset-driven model state
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rptr <= 0;
    else if (o_fifo_ren) rptr <= rptr + 1;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (o_fifo_ren) ren_pulses <= ren_pulses + 1;
      if (sif.valid && sif.ready) got_q.push_back(sif.data);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_load(input int n, input logic [3:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[wptr % 64] = base + 4'(i);
      wptr = wptr + 1;
    end
  endtask

  task automatic wait_got(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (got_q.size() >= n) break;
      tick();
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words, required %0d", got_q.size(), n);
    end
  endtask

  task automatic compare_got(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d words, required %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_word%0d: got %h, required %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    #2;
    checks++; if (o_fifo_ren !== 1'b0) begin errors++; $display("FAIL rst_ren: got %b, required 0", o_fifo_ren); end
    checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", sif.valid); end
    checks++; if (sif.data !== 4'h0) begin errors++; $display("FAIL rst_data: got %h, required 0", sif.data); end
    checks++; if (count8 !== 8'h00) begin errors++; $display("FAIL rst_count: got %h, required 00", count8); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int p0;
    en = 1'b1; sif.ready = 1'b1; got_q.delete(); p0 = ren_pulses;
    fifo_load(8, 4'h1);
    tick();
    checks++; if (o_fifo_ren !== 1'b1) begin errors++; $display("FAIL stream_ren_issue: got %b, required 1", o_fifo_ren); end
    checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL stream_valid_early: got %b, required 0", sif.valid); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (sif.valid !== 1'b1 || sif.data !== 4'(k)) begin
        errors++;
        $display("FAIL stream_word%0d: got valid=%b data=%h, required valid=1 data=%h", k, sif.valid, sif.data, 4'(k));
      end
    end
    tick();
    checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL stream_valid_end: got %b, required 0", sif.valid); end
    checks++; if (ren_pulses - p0 !== 8) begin errors++; $display("FAIL stream_pulses: got %0d, required 8", ren_pulses - p0); end
    checks++; if (count8 !== 8'd8) begin errors++; $display("FAIL stream_count: got %0d, required 8", count8); end
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    compare_got("stream");
  endtask

  task automatic test_backpressure();
    int p0;
    en = 1'b1; sif.ready = 1'b0; got_q.delete(); p0 = ren_pulses;
    fifo_load(6, 4'h1);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c >= 2) begin
        checks++;
        if (sif.valid !== 1'b1 || sif.data !== 4'h1) begin
          errors++;
          $display("FAIL bp_hold_c%0d: got valid=%b data=%h, required valid=1 data=1", c, sif.valid, sif.data);
        end
      end
    end
    checks++; if (ren_pulses - p0 !== 2) begin errors++; $display("FAIL bp_pulses: got %0d, required 2", ren_pulses - p0); end
    checks++; if (dut.u_buf.o_occ !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d, required 2", dut.u_buf.o_occ); end
    sif.ready = 1'b1;
    wait_got(6, 40);
    tick(); tick();
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    compare_got("bp");
    checks++; if (ren_pulses - p0 !== 6) begin errors++; $display("FAIL bp_total_pulses: got %0d, required 6", ren_pulses - p0); end
  endtask

  task automatic test_empty_rise();
    int p0;
    en = 1'b1; sif.ready = 1'b1; got_q.delete(); p0 = ren_pulses;
    fifo_load(8, 4'h1);
    tick(); tick(); tick();
    force_empty = 1'b1;
    tick();
    checks++; if (o_fifo_ren !== 1'b0) begin errors++; $display("FAIL empty_ren_drop: got %b, required 0", o_fifo_ren); end
    tick();
    checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b, required 0", sif.valid); end
    tick(); tick();
    checks++; if (ren_pulses - p0 !== 3) begin errors++; $display("FAIL empty_pulses: got %0d, required 3", ren_pulses - p0); end
    exp_q = '{4'h1, 4'h2, 4'h3};
    compare_got("empty_first3");
    force_empty = 1'b0;
    wait_got(8, 40);
    tick(); tick();
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    compare_got("empty_all");
  endtask

  task automatic test_en_drop();
    int p0;
    en = 1'b1; sif.ready = 1'b1; got_q.delete(); p0 = ren_pulses;
    fifo_load(4, 4'hA);
    tick();
    checks++; if (o_fifo_ren !== 1'b1) begin errors++; $display("FAIL en_issue: got %b, required 1", o_fifo_ren); end
    en = 1'b0;
    tick();
    checks++; if (o_fifo_ren !== 1'b0) begin errors++; $display("FAIL en_ren_off: got %b, required 0", o_fifo_ren); end
    checks++;
    if (sif.valid !== 1'b1 || sif.data !== 4'hA) begin
      errors++;
      $display("FAIL en_inflight: got valid=%b data=%h, required valid=1 data=a", sif.valid, sif.data);
    end
    tick(); tick(); tick(); tick();
    checks++; if (ren_pulses - p0 !== 1) begin errors++; $display("FAIL en_pulses: got %0d, required 1", ren_pulses - p0); end
    checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL en_idle_valid: got %b, required 0", sif.valid); end
    exp_q = '{4'hA};
    compare_got("en_held");
    en = 1'b1;
    wait_got(4, 40);
    tick(); tick();
    exp_q = '{4'hA, 4'hB, 4'hC, 4'hD};
    compare_got("en_resume");
  endtask

  task automatic test_reset_mid();
    en = 1'b1; sif.ready = 1'b1; got_q.delete();
    fifo_load(8, 4'h1);
    tick(); tick();
    checks++;
    if (dut.u_buf.o_occ !== 2'd1 || o_fifo_ren !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got occ=%0d ren=%b, required occ=1 ren=1", dut.u_buf.o_occ, o_fifo_ren);
    end
    #2;
    rst_n = 1'b0;
    wptr = 0;
    #1;
    checks++; if (o_fifo_ren !== 1'b0) begin errors++; $display("FAIL mid_rst_ren: got %b, required 0", o_fifo_ren); end
    checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, required 0", sif.valid); end
    checks++; if (sif.data !== 4'h0) begin errors++; $display("FAIL mid_rst_data: got %h, required 0", sif.data); end
    checks++; if (count8 !== 8'h00 || count4 !== 4'h0) begin errors++; $display("FAIL mid_rst_count: got %h/%h, required 00/0", count8, count4); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    tick(); tick(); tick();
    checks++;
    if (sif.valid !== 1'b0 || sif.data !== 4'h0 || o_fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL mid_stale: got valid=%b data=%h ren=%b, required 0/0/0", sif.valid, sif.data, o_fifo_ren);
    end
    fifo_load(2, 4'h5);
    wait_got(2, 20);
    tick(); tick();
    exp_q = '{4'h5, 4'h6};
    compare_got("mid_after");
  endtask

  task automatic test_count_wrap();
    rst_n = 1'b0; wptr = 0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; sif.ready = 1'b1; got_q.delete();
    tick();
    fifo_load(17, 4'h0);
    for (int t = 0; t <= 18; t++) begin
      tick();
      if (t == 16) begin
        checks++; if (count4 !== 4'hF) begin errors++; $display("FAIL wrap_15: got %h, required f", count4); end
      end
      if (t == 17) begin
        checks++; if (count4 !== 4'h0) begin errors++; $display("FAIL wrap_16: got %h, required 0", count4); end
      end
      if (t == 18) begin
        checks++; if (count4 !== 4'h1) begin errors++; $display("FAIL wrap_17: got %h, required 1", count4); end
        checks++; if (count8 !== 8'h11) begin errors++; $display("FAIL wrap_count8: got %h, required 11", count8); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; force_empty = 1'b0; sif.ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_rise();
    test_en_drop();
    test_reset_mid();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
endmodule
